// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register-file write port, merges ALU results and load returns.
// Optional byte/halfword load extension is enabled with `define WB_SUBWORD_LOAD_EN.
module wb_arbiter #(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int REG_CODE_LENGTH = 5,
  parameter int SKID_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_wb_valid,
  input  logic [REG_CODE_LENGTH-1:0] alu_wb_rd,
  input  logic [REG_DATA_WIDTH-1:0]  alu_wb_data,
  output logic                       alu_wb_ready,
  input  logic                       ld_issue_valid,
  input  logic [REG_CODE_LENGTH-1:0] ld_issue_rd,
  input  logic [2:0]                 ld_issue_funct3,
  input  logic [1:0]                 ld_issue_addr_lo,
  output logic                       ld_issue_ready,
  input  logic                       mem_rvalid,
  input  logic [REG_DATA_WIDTH-1:0]  mem_rdata,
  input  logic [REG_CODE_LENGTH-1:0] dec_rs1,
  input  logic [REG_CODE_LENGTH-1:0] dec_rs2,
  input  logic [REG_CODE_LENGTH-1:0] dec_rd,
  output logic                       hazard_stall,
  output logic                       RegWrite,
  output logic [REG_CODE_LENGTH-1:0] w_rg,
  output logic [REG_DATA_WIDTH-1:0]  w_data
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {LD_IDLE = 1'b0, LD_WAIT = 1'b1} ld_state_e;

  ld_state_e                  state_q, state_d;
  logic [REG_CODE_LENGTH-1:0] ld_rd_q, ld_rd_d;
  logic [REG_CODE_LENGTH-1:0] fifo_rd_q [SKID_DEPTH];
  logic [REG_CODE_LENGTH-1:0] fifo_rd_d [SKID_DEPTH];
  logic [REG_DATA_WIDTH-1:0]  fifo_data_q [SKID_DEPTH];
  logic [REG_DATA_WIDTH-1:0]  fifo_data_d [SKID_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       regwrite_q, regwrite_d;
  logic [REG_CODE_LENGTH-1:0] w_rg_q, w_rg_d;
  logic [REG_DATA_WIDTH-1:0]  w_data_q, w_data_d;

  logic                       fifo_empty, ld_return, alu_take, push, pop;
  logic [REG_DATA_WIDTH-1:0]  ld_data;
  logic [SKID_DEPTH-1:0]      entry_valid;
  logic [PTR_W-1:0]           offs;

`ifdef WB_SUBWORD_LOAD_EN
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = mem_rdata[{ld_addr_lo_q, 3'b000} +: 8];
    ld_half = ld_addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3_q)
      3'b000:  ld_data = {{(REG_DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(REG_DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(REG_DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(REG_DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end
`else
  logic unused_ld_fields;
  assign unused_ld_fields = ^{ld_issue_funct3, ld_issue_addr_lo};
  assign ld_data = mem_rdata;
`endif

  function automatic logic any_hit(input logic [REG_CODE_LENGTH-1:0] a, b, c, t);
    return (t != '0) && ((a == t) || (b == t) || (c == t));
  endfunction

  always_comb begin
    fifo_empty     = (count_q == '0);
    alu_wb_ready   = (count_q != CNT_W'(SKID_DEPTH));
    ld_return      = (state_q == LD_WAIT) && mem_rvalid;
    ld_issue_ready = fifo_empty && ((state_q == LD_IDLE) || mem_rvalid);
    alu_take       = alu_wb_valid && alu_wb_ready && (alu_wb_rd != '0);
    pop            = !ld_return && !fifo_empty;
    // a taken ALU result skips the FIFO only when the port is free and nothing older is queued
    push           = alu_take && (ld_return || !fifo_empty);

    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = alu_wb_rd;
      fifo_data_d[wr_ptr_q] = alu_wb_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    regwrite_d = 1'b0;
    w_rg_d     = w_rg_q;
    w_data_d   = w_data_q;
    if (ld_return) begin
      regwrite_d = (ld_rd_q != '0);
      w_rg_d     = ld_rd_q;
      w_data_d   = ld_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      w_rg_d     = fifo_rd_q[rd_ptr_q];
      w_data_d   = fifo_data_q[rd_ptr_q];
    end else if (alu_take) begin
      regwrite_d = 1'b1;
      w_rg_d     = alu_wb_rd;
      w_data_d   = alu_wb_data;
    end

    state_d = state_q;
    ld_rd_d = ld_rd_q;
`ifdef WB_SUBWORD_LOAD_EN
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
`endif
    if (ld_issue_valid && ld_issue_ready) begin
      state_d = LD_WAIT;
      ld_rd_d = ld_issue_rd;
`ifdef WB_SUBWORD_LOAD_EN
      ld_funct3_d  = ld_issue_funct3;
      ld_addr_lo_d = ld_issue_addr_lo;
`endif
    end else if (ld_return) begin
      state_d = LD_IDLE;
    end
  end

  always_comb begin
    offs         = '0;
    entry_valid  = '0;
    hazard_stall = 1'b0;
    if ((state_q == LD_WAIT) && any_hit(dec_rs1, dec_rs2, dec_rd, ld_rd_q)) hazard_stall = 1'b1;
    if (regwrite_q && any_hit(dec_rs1, dec_rs2, dec_rd, w_rg_q)) hazard_stall = 1'b1;
    for (int i = 0; i < SKID_DEPTH; i++) begin
      offs           = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offs} < count_q);
      if (entry_valid[i] && any_hit(dec_rs1, dec_rs2, dec_rd, fifo_rd_q[i])) hazard_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      ld_rd_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      w_rg_q     <= '0;
      w_data_q   <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
`ifdef WB_SUBWORD_LOAD_EN
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      regwrite_q  <= regwrite_d;
      w_rg_q      <= w_rg_d;
      w_data_q    <= w_data_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
`ifdef WB_SUBWORD_LOAD_EN
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
`endif
    end
  end

  assign RegWrite = regwrite_q;
  assign w_rg     = w_rg_q;
  assign w_data   = w_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level reference model predicts every register-file write.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid, alu_wb_ready, ld_issue_valid, ld_issue_ready, mem_rvalid;
  logic [4:0]  alu_wb_rd, ld_issue_rd, dec_rs1, dec_rs2, dec_rd, w_rg;
  logic [31:0] alu_wb_data, mem_rdata, w_data;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_addr_lo;
  logic        hazard_stall, RegWrite;

  wb_arbiter #(.REG_DATA_WIDTH(32), .REG_CODE_LENGTH(5), .SKID_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
    .ld_issue_addr_lo(ld_issue_addr_lo), .ld_issue_ready(ld_issue_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard_stall(hazard_stall),
    .RegWrite(RegWrite), .w_rg(w_rg), .w_data(w_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wr_t;

  wr_t        exp_q[$];
  wr_t        m_fifo[$];
  bit         m_wait, m_we, alu_accepted, alu_hold;
  logic [4:0] m_rd, m_rg;
  logic [2:0] m_f3;
  logic [1:0] m_lo;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
`ifdef WB_SUBWORD_LOAD_EN
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = lo[1] ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
`else
    if (f3 == 3'b000 && lo == 2'b00) return w;
    return w;
`endif
  endfunction

  function automatic bit hit3(input logic [4:0] t);
    return (t != 5'd0) && (dec_rs1 == t || dec_rs2 == t || dec_rd == t);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_we = 0; m_rg = 0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  // called right after inputs are driven on the falling edge; predicts the next rising edge
  task automatic step();
    bit  alu_rdy, ld_rdy, ret, haz;
    wr_t w;
    #1;
    alu_rdy = (m_fifo.size() < DEPTH);
    ld_rdy  = (m_fifo.size() == 0) && (!m_wait || mem_rvalid);
    haz     = (m_wait && hit3(m_rd)) || (m_we && hit3(m_rg));
    foreach (m_fifo[i]) if (hit3(m_fifo[i].rd)) haz = 1;
    chk("alu_wb_ready", {31'b0, alu_wb_ready}, {31'b0, alu_rdy});
    chk("ld_issue_ready", {31'b0, ld_issue_ready}, {31'b0, ld_rdy});
    chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, haz});
    ret          = m_wait && mem_rvalid;
    alu_accepted = alu_wb_valid && alu_rdy;
    m_we = 0;
    if (ret) begin
      if (m_rd != 0) begin
        w.rd = m_rd; w.data = ext(mem_rdata, m_f3, m_lo);
        exp_q.push_back(w); m_we = 1; m_rg = m_rd;
      end
      if (alu_accepted && alu_wb_rd != 0) begin
        w.rd = alu_wb_rd; w.data = alu_wb_data; m_fifo.push_back(w);
      end
    end else if (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      exp_q.push_back(w); m_we = 1; m_rg = w.rd;
      if (alu_accepted && alu_wb_rd != 0) begin
        w.rd = alu_wb_rd; w.data = alu_wb_data; m_fifo.push_back(w);
      end
    end else if (alu_accepted && alu_wb_rd != 0) begin
      w.rd = alu_wb_rd; w.data = alu_wb_data;
      exp_q.push_back(w); m_we = 1; m_rg = alu_wb_rd;
    end
    if (ld_issue_valid && ld_rdy) begin
      m_wait = 1; m_rd = ld_issue_rd; m_f3 = ld_issue_funct3; m_lo = ld_issue_addr_lo;
    end else if (ret) begin
      m_wait = 0;
    end
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (RegWrite === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("w_rg", {27'b0, w_rg}, {27'b0, e.rd});
          chk("w_data", w_data, e.data);
        end else begin
          chk("spurious_regwrite", {31'b0, RegWrite}, 32'd0);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("missing_regwrite", {31'b0, RegWrite}, 32'd1);
      end
    end
  end

  task automatic idle_inputs();
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic do_reset_now();
    rst = 1;
    #1;
    chk("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_w_rg", {27'b0, w_rg}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_alu_ready", {31'b0, alu_wb_ready}, 32'd1);
    chk("rst_ld_ready", {31'b0, ld_issue_ready}, 32'd1);
    chk("rst_hazard", {31'b0, hazard_stall}, 32'd0);
    model_reset();
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ld_issue_valid = 1; ld_issue_rd = rd; ld_issue_funct3 = f3; ld_issue_addr_lo = lo;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); idle_inputs(); step();
    end
  endtask

  initial begin : stimulus
    idle_inputs();
    dec_rs1 = 5;
    model_reset();
    @(negedge clk);
    do_reset_now();
    @(negedge clk);
    rst = 0;

    // direct ALU write and its one-cycle hazard window
    idle_inputs(); alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'h1234_5678; step();
    @(negedge clk); idle_inputs(); dec_rs1 = 5; step();
    chk("direct_w_rg", {27'b0, w_rg}, 32'd5);
    chk("direct_w_data", w_data, 32'h1234_5678);
    chk("direct_hazard", {31'b0, hazard_stall}, 32'd1);

    // LB rd=3 addr_lo=2
    @(negedge clk); idle_inputs(); issue_load(5'd3, 3'b000, 2'd2); step();
    @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h0080_0000; step();
    @(negedge clk); idle_inputs();
`ifdef WB_SUBWORD_LOAD_EN
    chk("lb_data", w_data, 32'hFFFF_FF80);
`else
    chk("lb_data", w_data, 32'h0080_0000);
`endif
    step();

    // LHU rd=4 addr_lo=2
    @(negedge clk); idle_inputs(); issue_load(5'd4, 3'b101, 2'd2); step();
    @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'hBEEF_0000; step();
    @(negedge clk); idle_inputs();
`ifdef WB_SUBWORD_LOAD_EN
    chk("lhu_data", w_data, 32'h0000_BEEF);
`else
    chk("lhu_data", w_data, 32'hBEEF_0000);
`endif
    step();

    // two collisions fill the skid FIFO, the third result must wait
    @(negedge clk); idle_inputs(); issue_load(5'd9, 3'b010, 2'd0); dec_rs2 = 9; step();
    @(negedge clk); idle_inputs(); dec_rs2 = 9; issue_load(5'd10, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h11; alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'hA; step();
    @(negedge clk); idle_inputs(); dec_rs2 = 9;
    mem_rvalid = 1; mem_rdata = 32'h22; alu_wb_valid = 1; alu_wb_rd = 8; alu_wb_data = 32'hB; step();
    @(negedge clk); idle_inputs(); dec_rs2 = 9; alu_wb_valid = 1; alu_wb_rd = 11; alu_wb_data = 32'hC; step();
    chk("full_alu_ready", {31'b0, alu_wb_ready}, 32'd0);
    for (int i = 0; i < 8 && !alu_accepted; i++) begin
      @(negedge clk); step();
    end
    chk("held_result_accepted", {31'b0, alu_accepted}, 32'd1);
    idle_cycles(4);

    // rd=0 ALU result never reaches the port
    @(negedge clk); idle_inputs(); alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'hDEAD; step();
    idle_cycles(2);

    // reset while a load is pending with a queued ALU result
    @(negedge clk); idle_inputs(); issue_load(5'd12, 3'b010, 2'd0); step();
    @(negedge clk); idle_inputs(); issue_load(5'd13, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h33; alu_wb_valid = 1; alu_wb_rd = 14; alu_wb_data = 32'hE; step();
    @(negedge clk); idle_inputs(); dec_rs1 = 13; dec_rs2 = 14;
    do_reset_now();
    @(negedge clk); rst = 0; idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h44; step();
    idle_cycles(2);

    // randomized traffic
    alu_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        idle_inputs();
        do_reset_now();
        alu_hold = 0;
        @(negedge clk);
        rst = 0;
      end
      if (!alu_hold) begin
        alu_wb_valid = ($urandom_range(0, 99) < 60);
        alu_wb_rd    = 5'($urandom_range(0, 7));
        alu_wb_data  = $urandom;
      end
      ld_issue_valid   = ($urandom_range(0, 99) < 40);
      ld_issue_rd      = 5'($urandom_range(0, 7));
      ld_issue_funct3  = 3'($urandom_range(0, 7));
      ld_issue_addr_lo = 2'($urandom_range(0, 3));
      mem_rvalid       = ($urandom_range(0, 99) < 40);
      mem_rdata        = $urandom;
      dec_rs1          = 5'($urandom_range(0, 7));
      dec_rs2          = 5'($urandom_range(0, 7));
      dec_rd           = 5'($urandom_range(0, 7));
      step();
      alu_hold = alu_wb_valid && !alu_accepted;
    end

    idle_cycles(6);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
